// File: rtl/add16u_err_monitor.sv
// Streaming error characterisation for approximate unsigned adders: recomputes the exact sum
// and accumulates error count, sum of absolute error and worst-case error over a sample run.
module add16u_err_monitor #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_samples_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_a_i,
  input  logic [W-1:0]     in_b_i,
  input  logic [W:0]       in_o_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [ACC_W-1:0] sae_o,
  output logic             sae_sat_o,
  output logic [W:0]       wce_o,
  output logic [W-1:0]     wce_a_o,
  output logic [W-1:0]     wce_b_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             drain_wait_q, drain_wait_d;
  logic             done_q, done_d;
  logic             clear, hs;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [W:0]       s1_o_q, s1_exact_q;
  logic             s2_valid_q;
  logic [W-1:0]     s2_a_q, s2_b_q;
  logic [W:0]       s2_d_q, diff;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sae_q, sae_d;
  logic [ACC_W:0]   sae_sum;
  logic             sae_sat_q, sae_sat_d;
  logic [W:0]       wce_q, wce_d;
  logic [W-1:0]     wce_a_q, wce_a_d, wce_b_q, wce_b_d;

  assign in_ready_o = (state_q == StRun) && (remaining_q != '0);
  assign hs         = in_valid_i && in_ready_o;
  assign busy_o     = (state_q == StRun) || (state_q == StDrain);
  assign done_o     = done_q;

  // DRAIN always lasts at least two cycles so done lands a fixed three edges after the
  // point where the last accept could have happened, even for an empty run.
  always_comb begin
    state_d      = state_q;
    drain_wait_d = 1'b0;
    done_d       = 1'b0;
    clear        = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StRun;
          clear   = 1'b1;
        end
      end
      StRun: begin
        if (remaining_q == '0) begin
          state_d      = StDrain;
          drain_wait_d = 1'b1;
        end
      end
      StDrain: begin
        if (!drain_wait_q && !s1_valid_q && !s2_valid_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    remaining_d = remaining_q;
    if (clear) begin
      remaining_d = n_samples_i;
    end else if (hs) begin
      remaining_d = remaining_q - CNT_W'(1);
    end
  end

  assign diff    = (s1_exact_q >= s1_o_q) ? (s1_exact_q - s1_o_q) : (s1_o_q - s1_exact_q);
  assign sae_sum = {1'b0, sae_q} + (ACC_W+1)'(s2_d_q);

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sae_d        = sae_q;
    sae_sat_d    = sae_sat_q;
    wce_d        = wce_q;
    wce_a_d      = wce_a_q;
    wce_b_d      = wce_b_q;
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sae_d        = '0;
      sae_sat_d    = 1'b0;
      wce_d        = '0;
      wce_a_d      = '0;
      wce_b_d      = '0;
    end else if (s2_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      err_cnt_d    = err_cnt_q + CNT_W'(s2_d_q != '0);
      if (sae_sat_q || sae_sum[ACC_W]) begin
        sae_d     = '1;
        sae_sat_d = 1'b1;
      end else begin
        sae_d = sae_sum[ACC_W-1:0];
      end
      // Strictly greater: ties keep the earliest sample.
      if (s2_d_q > wce_q) begin
        wce_d   = s2_d_q;
        wce_a_d = s2_a_q;
        wce_b_d = s2_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      drain_wait_q <= 1'b0;
      done_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_o_q       <= '0;
      s1_exact_q   <= '0;
      s2_valid_q   <= 1'b0;
      s2_a_q       <= '0;
      s2_b_q       <= '0;
      s2_d_q       <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sae_q        <= '0;
      sae_sat_q    <= 1'b0;
      wce_q        <= '0;
      wce_a_q      <= '0;
      wce_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      drain_wait_q <= drain_wait_d;
      done_q       <= done_d;
      s1_valid_q   <= hs && !clear;
      if (hs) begin
        s1_a_q     <= in_a_i;
        s1_b_q     <= in_b_i;
        s1_o_q     <= in_o_i;
        s1_exact_q <= {1'b0, in_a_i} + {1'b0, in_b_i};
      end
      s2_valid_q   <= s1_valid_q && !clear;
      s2_a_q       <= s1_a_q;
      s2_b_q       <= s1_b_q;
      s2_d_q       <= diff;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sae_q        <= sae_d;
      sae_sat_q    <= sae_sat_d;
      wce_q        <= wce_d;
      wce_a_q      <= wce_a_d;
      wce_b_q      <= wce_b_d;
    end
  end

  assign sample_cnt_o = sample_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign sae_o        = sae_q;
  assign sae_sat_o    = sae_sat_q;
  assign wce_o        = wce_q;
  assign wce_a_o      = wce_a_q;
  assign wce_b_o      = wce_b_q;

endmodule
